instr_fetch_unit: RTL

Instruction fetch front end for the RISC-V core: owns the program counter, issues word reads to a synchronous instruction memory, and buffers returned instructions in a small FIFO. It feeds the decoder/register-file stage over a valid/ready handshake and accepts redirects from branch/jump resolution. It sits upstream of the decoder and supplies the `instr` word that the decoder consumes.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch front end. It issues word reads to a
// synchronous instruction memory and buffers the responses in a small FIFO.
// The FIFO head is presented to the decoder over a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at the new PC.
module instr_fetch_unit #(
  parameter int unsigned           XLEN       = 32,
  parameter logic [XLEN-1:0]       RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_kill;

  logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic [CW:0]     w_occ;

  // Handshake and occupancy terms shared by the FSM outputs and datapath
  always_comb begin
    w_pop  = instr_valid && instr_ready;
    w_push = r_inflight && !r_kill && !redirect_valid;
    w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOOT;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: BOOT lasts exactly one cycle after reset release
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Output logic: request only when the response is guaranteed a FIFO slot
  always_comb begin
    w_req = 1'b0;
    if (r_state == RUN && !redirect_valid && (w_occ < (CW+1)'(FIFO_DEPTH)))
      w_req = 1'b1;
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_data[r_rptr];
  assign instr_pc    = r_fifo_pc[r_rptr];

  // PC, in-flight tracking and kill flag; redirect takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc & ~XLEN'(3);
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= w_req;
      if (w_req) begin
        r_pc     <= r_pc + XLEN'(4);
        r_req_pc <= r_pc;
      end
    end
  end

  // Instruction FIFO storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wptr]   <= r_req_pc;
        r_fifo_data[r_wptr] <= imem_rdata;
        r_wptr              <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Request gating must never let a response land in a full FIFO
  always_ff @(posedge clk) begin
    if (rst)
      assert (!(w_push && !w_pop && r_count == CW'(FIFO_DEPTH)));
  end

endmodule
